regfile_wb_arbiter: RTL and testbench

//  Shares the single write port of the 16-entry register file between NUM_REQ writeback sources.

---
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Purpose  : Round-robin arbiter for the register-file write port, with a
//             registered write stage and a busy scoreboard for RAW hazards.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 31,
    parameter int ADDR_MSB   = 3,
    parameter int NUM_REQ    = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req,
    input  logic [NUM_REQ*(ADDR_MSB+1)-1:0]   req_addr,
    input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0] req_data,
    output logic [NUM_REQ-1:0]                gnt,
    output logic [DATA_WIDTH:0]               data_In,
    output logic [ADDR_MSB:0]                 data_InReg,
    output logic                              enable,
    input  logic                              rsv_valid,
    input  logic [ADDR_MSB:0]                 rsv_addr,
    input  logic [ADDR_MSB:0]                 chk_addrA,
    input  logic [ADDR_MSB:0]                 chk_addrB,
    output logic                              hazardA,
    output logic                              hazardB,
    output logic [(2**(ADDR_MSB+1))-1:0]      busy
);

    localparam int c_AW    = ADDR_MSB + 1;
    localparam int c_DW    = DATA_WIDTH + 1;
    localparam int c_NREG  = 2 ** c_AW;
    localparam int c_PTR_W = $clog2(NUM_REQ);
    localparam logic [c_PTR_W:0]   c_NUM  = (c_PTR_W + 1)'(NUM_REQ);
    localparam logic [c_PTR_W-1:0] c_LAST = c_PTR_W'(NUM_REQ - 1);

    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_sel;
    logic [c_PTR_W:0]   w_idx;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_gnt;
    logic [c_AW-1:0]    w_addr;
    logic [c_DW-1:0]    w_data;
    logic [c_NREG-1:0]  r_busy;
    logic [c_NREG-1:0]  w_busy_nxt;
    logic [c_DW-1:0]    r_data;
    logic [c_AW-1:0]    r_addr;
    logic               r_en;

    // Scan ptr, ptr+1, ... with wrap; the first asserted request wins.
    always_comb begin
        w_gnt  = '0;
        w_xfer = 1'b0;
        w_sel  = '0;
        w_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (c_PTR_W + 1)'(k);
            if (w_idx >= c_NUM) w_idx = w_idx - c_NUM;
            if (!w_xfer && req[w_idx[c_PTR_W-1:0]]) begin
                w_xfer = 1'b1;
                w_sel  = w_idx[c_PTR_W-1:0];
            end
        end
        if (rst) w_xfer = 1'b0;
        if (w_xfer) w_gnt[w_sel] = 1'b1;
    end

    assign w_addr = req_addr[w_sel*c_AW +: c_AW];
    assign w_data = req_data[w_sel*c_DW +: c_DW];

    // Reservation is applied after the clear so a newer producer keeps the bit.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_xfer)    w_busy_nxt[w_addr]   = 1'b0;
        if (rsv_valid) w_busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr  <= '0;
            r_busy <= '0;
            r_en   <= 1'b0;
            r_data <= '0;
            r_addr <= '0;
        end else begin
            r_en   <= w_xfer;
            r_busy <= w_busy_nxt;
            if (w_xfer) begin
                r_data <= w_data;
                r_addr <= w_addr;
                r_ptr  <= (w_sel == c_LAST) ? '0 : w_sel + 1'b1;
            end
        end
    end

    assign gnt        = w_gnt;
    assign data_In    = r_data;
    assign data_InReg = r_addr;
    assign enable     = r_en;
    assign busy       = r_busy;
    assign hazardA    = r_busy[chk_addrA];
    assign hazardB    = r_busy[chk_addrB];

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Purpose  : Scoreboard bench for regfile_wb_arbiter against a queue/array
//             reference model of round-robin writeback and busy tracking.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int N = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N*4-1:0]  req_addr;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    gnt;
    logic [31:0]     data_In;
    logic [3:0]      data_InReg;
    logic            enable;
    logic            rsv_valid;
    logic [3:0]      rsv_addr;
    logic [3:0]      chk_addrA;
    logic [3:0]      chk_addrB;
    logic            hazardA;
    logic            hazardB;
    logic [15:0]     busy;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_WIDTH(31), .ADDR_MSB(3), .NUM_REQ(N)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .data_In(data_In), .data_InReg(data_InReg), .enable(enable),
        .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .chk_addrA(chk_addrA),
        .chk_addrB(chk_addrB), .hazardA(hazardA), .hazardB(hazardB), .busy(busy)
    );

    typedef struct {
        logic        en;
        logic [31:0] din;
        logic [3:0]  dreg;
        logic [15:0] busy;
    } reg_exp_t;

    typedef struct {
        logic [N-1:0] gnt;
        logic         ha;
        logic         hb;
    } comb_exp_t;

    reg_exp_t  rq[$];
    comb_exp_t cq[$];
    int checks = 0;
    int errors = 0;

    // Reference state: what the register file interface should look like.
    int          m_ptr  = 0;
    logic [15:0] m_busy = '0;
    logic        m_en   = 1'b0;
    logic [31:0] m_din  = '0;
    logic [3:0]  m_dreg = '0;
    int          last_g = -1;

    logic [3:0]  s_addr[N];
    logic [31:0] s_data[N];
    bit          s_pend[N];

    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Predictor: applies one clock edge of the reference model.
    initial begin
        forever begin
            int g;
            reg_exp_t e;
            @(posedge clk);
            if (rst) begin
                m_ptr = 0; m_busy = '0; m_en = 1'b0; m_din = '0; m_dreg = '0;
            end else begin
                g = pick(m_ptr, req);
                if (g >= 0) begin
                    m_en   = 1'b1;
                    m_din  = req_data[g*32 +: 32];
                    m_dreg = req_addr[g*4 +: 4];
                    m_busy[m_dreg] = 1'b0;
                    m_ptr  = (g + 1) % N;
                end else begin
                    m_en = 1'b0;
                end
                if (rsv_valid) m_busy[rsv_addr] = 1'b1;
            end
            e.en = m_en; e.din = m_din; e.dreg = m_dreg; e.busy = m_busy;
            rq.push_back(e);
        end
    end

    // Monitor: compares DUT outputs mid-cycle against queued expectations.
    initial begin
        forever begin
            reg_exp_t  e;
            comb_exp_t c;
            @(negedge clk);
            if (rq.size() > 0) begin
                e = rq.pop_front();
                check("enable",     {31'b0, enable}, {31'b0, e.en});
                check("data_In",    data_In,          e.din);
                check("data_InReg", {28'b0, data_InReg}, {28'b0, e.dreg});
                check("busy",       {16'b0, busy},   {16'b0, e.busy});
            end
            if (cq.size() > 0) begin
                c = cq.pop_front();
                check("gnt",     {29'b0, gnt},     {29'b0, c.gnt});
                check("hazardA", {31'b0, hazardA}, {31'b0, c.ha});
                check("hazardB", {31'b0, hazardB}, {31'b0, c.hb});
            end
        end
    end

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req[i]              = s_pend[i];
            req_addr[i*4 +: 4]  = s_addr[i];
            req_data[i*32 +: 32] = s_data[i];
        end
    endtask

    // Drives the cycle's inputs and records the expected combinational outputs.
    task automatic commit();
        comb_exp_t c;
        int g;
        pack();
        g = rst ? -1 : pick(m_ptr, req);
        c.gnt = '0;
        if (g >= 0) c.gnt[g] = 1'b1;
        c.ha = m_busy[chk_addrA];
        c.hb = m_busy[chk_addrB];
        cq.push_back(c);
        last_g = g;
    endtask

    // Advances one cycle; a granted source drops its request by default.
    task automatic step();
        @(posedge clk);
        #1;
        if (last_g >= 0) s_pend[last_g] = 1'b0;
        rst       = 1'b0;
        rsv_valid = 1'b0;
    endtask

    task automatic set_src(input int i, input logic [3:0] a, input logic [31:0] d);
        s_pend[i] = 1'b1;
        s_addr[i] = a;
        s_data[i] = d;
    endtask

    task automatic idle_all();
        for (int i = 0; i < N; i++) s_pend[i] = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rsv_valid = 1'b0; rsv_addr = '0; chk_addrA = '0; chk_addrB = '0;
        for (int i = 0; i < N; i++) set_src(i, 4'(i), 32'h1000 + 32'(i));
        pack();

        // Reset with every source requesting.
        repeat (3) begin
            step(); rst = 1'b1;
            for (int i = 0; i < N; i++) s_pend[i] = 1'b1;
            commit();
        end

        // Single write from source 1.
        step(); idle_all(); set_src(1, 4'd5, 32'hDEADBEEF); commit();
        step(); commit();
        step(); commit();

        // Round-robin with all sources requesting from ptr=0.
        step(); rst = 1'b1; commit();
        repeat (6) begin
            step();
            for (int i = 0; i < N; i++) set_src(i, 4'($urandom_range(0, 15)), $urandom);
            commit();
        end

        // Fairness: source 0 held, source 2 joins once ptr has moved to 1.
        step(); idle_all(); set_src(0, 4'd1, 32'hA0A0_0001); commit();
        repeat (5) begin
            step();
            set_src(0, 4'd2, $urandom);
            if (!s_pend[2]) set_src(2, 4'd3, $urandom);
            commit();
        end

        // Scoreboard: reserve, hazard, clear, then set-wins collision.
        step(); idle_all(); rsv_valid = 1'b1; rsv_addr = 4'd9; commit();
        step(); chk_addrA = 4'd9; chk_addrB = 4'd3; set_src(0, 4'd9, 32'h0000_0009); commit();
        step(); commit();
        step(); set_src(0, 4'd9, 32'h9999_0009); rsv_valid = 1'b1; rsv_addr = 4'd9; commit();
        step(); chk_addrB = 4'd9; commit();

        // Mid-operation reset while source 2 would be granted.
        step(); idle_all(); set_src(2, 4'd7, 32'h7777_0002); rsv_valid = 1'b1; rsv_addr = 4'd4;
        rst = 1'b1; commit();
        step(); for (int i = 0; i < N; i++) set_src(i, 4'(i + 10), $urandom); commit();
        step(); idle_all(); commit();

        // Randomized traffic with held requests, reservations and rare resets.
        repeat (600) begin
            step();
            for (int i = 0; i < N; i++)
                if (!s_pend[i] && $urandom_range(0, 99) < 50)
                    set_src(i, 4'($urandom_range(0, 15)), $urandom);
            rsv_valid = ($urandom_range(0, 99) < 35);
            rsv_addr  = ($urandom_range(0, 3) == 0) ? s_addr[$urandom_range(0, N - 1)]
                                                    : 4'($urandom_range(0, 15));
            chk_addrA = 4'($urandom_range(0, 15));
            chk_addrB = s_addr[$urandom_range(0, N - 1)];
            rst       = ($urandom_range(0, 99) < 2);
            commit();
        end

        repeat (3) begin step(); idle_all(); commit(); end
        @(negedge clk);
        #1;
        check("rq_drain", 32'(rq.size()), 32'd0);
        check("cq_drain", 32'(cq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
